// File: rtl/instr_pkg.sv
// instr_pkg: shared definitions for the instruction encoder and decoder.
// Format codes, field widths / bit positions of the 16-bit instruction word,
// and the loader FSM state type.
package instr_pkg;

  localparam int INSTR_W = 16;

  // Format codes carried on the fmt input
  localparam logic [1:0] FMT_D   = 2'd0;
  localparam logic [1:0] FMT_K   = 2'd1;
  localparam logic [1:0] FMT_S   = 2'd2;
  localparam logic [1:0] FMT_ILL = 2'd3;

  // Field widths and least-significant bit positions
  localparam int OP8_W   = 8;
  localparam int OP8_LSB = 8;
  localparam int OP4_W   = 4;
  localparam int OP4_LSB = 12;
  localparam int S4_W    = 4;
  localparam int S4_LSB  = 8;
  localparam int D7_W    = 7;
  localparam int D7_LSB  = 0;
  localparam int K8_W    = 8;
  localparam int K8_LSB  = 0;
  localparam int ARP_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } enc_state_e;

endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational field-to-word packer. Produces the 16-bit
// instruction word for D/K/S formats and flags the illegal format code.
module instr_pack
  import instr_pkg::*;
(
  input  logic [1:0]         fmt,
  input  logic [OP8_W-1:0]   op8,
  input  logic [OP4_W-1:0]   op4,
  input  logic [S4_W-1:0]    s4,
  input  logic [D7_W-1:0]    d7,
  input  logic [K8_W-1:0]    k8,
  input  logic               arp,
  output logic [INSTR_W-1:0] word,
  output logic               legal
);

  // Place each format's fields at their decoder bit positions
  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (fmt)
      FMT_D: begin
        word[OP8_LSB +: OP8_W] = op8;
        word[ARP_BIT]          = arp;
        word[D7_LSB +: D7_W]   = d7;
        legal                  = 1'b1;
      end
      FMT_K: begin
        word[OP8_LSB +: OP8_W] = op8;
        word[K8_LSB +: K8_W]   = k8;
        legal                  = 1'b1;
      end
      FMT_S: begin
        word[OP4_LSB +: OP4_W] = op4;
        word[S4_LSB +: S4_W]   = s4;
        word[K8_LSB +: K8_W]   = k8;
        legal                  = 1'b1;
      end
      FMT_ILL: begin
        legal = 1'b0;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: program loader. Packs decoded fields into instruction words
// and writes them sequentially into instruction memory, one per accepted
// bundle, behind an IDLE -> LOAD -> DONE session FSM.
// Optional feature macro INSTR_ENC_CHECKSUM_EN adds a checksum output holding
// the XOR of all words written in the current session.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [7:0]        op8,
  input  logic [3:0]        op4,
  input  logic [3:0]        s4,
  input  logic [6:0]        d7,
  input  logic [7:0]        k8,
  input  logic              arp,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              fmt_err
`ifdef INSTR_ENC_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  enc_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   rem_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [15:0]       wdata_q;
  logic              done_q;
  logic              fmt_err_q;

  logic [15:0]       word;
  logic              legal;
  logic              hs;

  instr_pack u_pack (
    .fmt   (fmt),
    .op8   (op8),
    .op4   (op4),
    .s4    (s4),
    .d7    (d7),
    .k8    (k8),
    .arp   (arp),
    .word  (word),
    .legal (legal)
  );

  // Handshake is only possible while loading
  assign hs = in_valid && (state_q == ST_LOAD);

  // Session FSM with counters and the registered memory write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      fmt_err_q <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q    <= base_addr;
            rem_q     <= word_count;
            fmt_err_q <= 1'b0;
            state_q   <= (word_count == '0) ? ST_DONE : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (hs) begin
            if (legal) begin
              we_q    <= 1'b1;
              waddr_q <= addr_q;
              wdata_q <= word;
              addr_q  <= addr_q + ADDR_W'(1);
              rem_q   <= rem_q - (ADDR_W+1)'(1);
              if (rem_q == (ADDR_W+1)'(1)) begin
                state_q <= ST_DONE;
              end
            end else begin
              fmt_err_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = (state_q == ST_LOAD);
  assign busy       = (state_q != ST_IDLE);
  assign imem_we    = we_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign done       = done_q;
  assign fmt_err    = fmt_err_q;

`ifdef INSTR_ENC_CHECKSUM_EN
  logic [15:0] chk_q;
  logic [15:0] chk_d;

  // Next checksum: cleared on session start, folded with each legal word
  always_comb begin
    chk_d = chk_q;
    if (state_q == ST_IDLE && start) begin
      chk_d = '0;
    end else if (hs && legal) begin
      chk_d = chk_q ^ word;
    end
  end

  // Checksum register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign checksum = chk_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table-driven bench with a write scoreboard for
// instr_encoder. Inputs change 1 time unit after the rising edge; the write
// monitor samples on the falling edge.
module tb_instr_encoder;

  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        fmt;
  logic [7:0]        op8;
  logic [3:0]        op4;
  logic [3:0]        s4;
  logic [6:0]        d7;
  logic [7:0]        k8;
  logic              arp;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic              fmt_err;
`ifdef INSTR_ENC_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fmt        (fmt),
    .op8        (op8),
    .op4        (op4),
    .s4         (s4),
    .d7         (d7),
    .k8         (k8),
    .arp        (arp),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .fmt_err    (fmt_err)
`ifdef INSTR_ENC_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  fmt;
    logic [7:0]  op8;
    logic [3:0]  op4;
    logic [3:0]  s4;
    logic [6:0]  d7;
    logic [7:0]  k8;
    logic        arp;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  vec_t              vt[8];
  wr_t               sbq[$];
  logic [ADDR_W-1:0] exp_addr;
  int                n_vec = 0;
  int                n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write
  always @(negedge clk) begin
    if (imem_we !== 1'b0) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_write: got we=%b addr=0x%0h data=0x%0h, expected no write",
                 imem_we, imem_addr, imem_wdata);
      end else begin
        wr_t w;
        w = sbq.pop_front();
        check("write_addr", 32'(imem_addr), 32'(w.addr));
        check("write_data", 32'(imem_wdata), 32'(w.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] cnt);
    start      = 1'b1;
    base_addr  = base;
    word_count = cnt;
    exp_addr   = base;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic send(input int i);
    fmt      = vt[i].fmt;
    op8      = vt[i].op8;
    op4      = vt[i].op4;
    s4       = vt[i].s4;
    d7       = vt[i].d7;
    k8       = vt[i].k8;
    arp      = vt[i].arp;
    in_valid = 1'b1;
    check("in_ready", 32'(in_ready), 32'd1);
    sbq.push_back('{addr: exp_addr, data: vt[i].exp});
    exp_addr = exp_addr + 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_illegal();
    fmt      = 2'd3;
    op8      = 8'h5A;
    op4      = 4'h9;
    s4       = 4'h6;
    d7       = 7'h33;
    k8       = 8'hC3;
    arp      = 1'b1;
    in_valid = 1'b1;
    check("in_ready_ill", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Called right after the final handshake edge: write visible now,
  // done one cycle later for exactly one cycle
  task automatic finish_session(input logic exp_err);
    check("in_ready_drop", 32'(in_ready), 32'd0);
    check("done_early", 32'(done), 32'd0);
    tick();
    check("done_pulse", 32'(done), 32'd1);
    check("fmt_err_at_done", 32'(fmt_err), 32'(exp_err));
    tick();
    check("done_low", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    // fmt, op8, op4, s4, d7, k8, arp, expected word
    vt[0] = '{2'd0, 8'h20, 4'h0, 4'h0, 7'h15, 8'h00, 1'b1, 16'h2095};
    vt[1] = '{2'd1, 8'hC0, 4'h0, 4'h0, 7'h00, 8'h7F, 1'b0, 16'hC07F};
    vt[2] = '{2'd2, 8'h00, 4'h3, 4'hA, 7'h00, 8'h55, 1'b0, 16'h3A55};
    vt[3] = '{2'd0, 8'hFF, 4'h5, 4'h5, 7'h7F, 8'hAA, 1'b0, 16'hFF7F};
    vt[4] = '{2'd1, 8'h01, 4'hE, 4'h7, 7'h55, 8'h80, 1'b1, 16'h0180};
    vt[5] = '{2'd2, 8'hAB, 4'hF, 4'h0, 7'h7F, 8'h01, 1'b1, 16'hF001};
    vt[6] = '{2'd0, 8'h00, 4'hF, 4'hF, 7'h00, 8'hFF, 1'b0, 16'h0000};
    vt[7] = '{2'd2, 8'hFF, 4'h0, 4'hF, 7'h7F, 8'hFF, 1'b1, 16'h0FFF};

    rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; in_valid = 1'b0;
    fmt = '0; op8 = '0; op4 = '0; s4 = '0; d7 = '0; k8 = '0; arp = 1'b0;
    exp_addr = '0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fmt_err", 32'(fmt_err), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", 32'(imem_wdata), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic three-format session
    start_session(10'h010, 11'd3);
    for (int i = 0; i < 3; i++) send(i);
    finish_session(1'b0);

    // Back-to-back table; a start pulse mid-session must be ignored
    start_session(10'h100, 11'd5);
    for (int i = 3; i < 8; i++) begin
      if (i == 5) begin
        start      = 1'b1;
        base_addr  = 10'h2AA;
        word_count = 11'd1;
      end else begin
        start = 1'b0;
      end
      send(i);
    end
    start = 1'b0;
    finish_session(1'b0);

    // Zero-length session
    start_session(10'h055, 11'd0);
    check("cnt0_in_ready", 32'(in_ready), 32'd0);
    check("cnt0_done_early", 32'(done), 32'd0);
    tick();
    check("cnt0_done", 32'(done), 32'd1);
    check("cnt0_in_ready2", 32'(in_ready), 32'd0);
    tick();
    check("cnt0_done_low", 32'(done), 32'd0);
    check("cnt0_busy", 32'(busy), 32'd0);

    // Illegal format mid-session
    start_session(10'h020, 11'd2);
    send(0);
    send_illegal();
    check("fmt_err_set", 32'(fmt_err), 32'd1);
    check("ill_in_ready", 32'(in_ready), 32'd1);
    send(1);
    finish_session(1'b1);
    check("fmt_err_sticky", 32'(fmt_err), 32'd1);

    // Address wrap; new start clears fmt_err
    start_session(10'h3FF, 11'd2);
    check("fmt_err_cleared", 32'(fmt_err), 32'd0);
    send(3);
    send(4);
    finish_session(1'b0);

    // Reset mid-session: pending bundle dropped, outputs cleared
    start_session(10'h200, 11'd4);
    send(0);
    fmt = vt[1].fmt; op8 = vt[1].op8; k8 = vt[1].k8;
    in_valid = 1'b1;
    rst_n    = 1'b0;
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b1;
    check("abort_we", 32'(imem_we), 32'd0);
    check("abort_addr", 32'(imem_addr), 32'd0);
    check("abort_wdata", 32'(imem_wdata), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    tick();
    tick();
    check("abort_still_idle", 32'(busy), 32'd0);
    start_session(10'h300, 11'd1);
    send(2);
    finish_session(1'b0);

`ifdef INSTR_ENC_CHECKSUM_EN
    start_session(10'h040, 11'd2);
    check("checksum_clear", 32'(checksum), 32'd0);
    send(0);
    send(1);
    tick();
    check("checksum_done_pulse", 32'(done), 32'd1);
    check("checksum_value", 32'(checksum), 32'hE0EA);
    tick();
`endif

    tick();
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
